// File: rtl/scrambler_multiblock_if.sv
// -----------------------------------------------------------------------------
// scrambler_multiblock_if
// Datapath bundle for scrambler_multiblock: the input word with its valid flag
// and the registered output word with its valid flag.
//   i_valid : input word qualifier
//   i_data  : DATA_W bits, block 0 in the MSBs (first on the wire)
//   o_data  : processed word, same block ordering
//   o_valid : o_data qualifier
// Modports: master = word source/sink (bench or upstream), slave = scrambler.
// -----------------------------------------------------------------------------
interface scrambler_multiblock_if #(
    parameter int unsigned DATA_W = 264
);
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;

    modport master (output i_valid, output i_data, input o_data, input o_valid);
    modport slave  (input i_valid, input i_data, output o_data, output o_valid);
endinterface

// File: rtl/scrambler_multiblock.sv
// -----------------------------------------------------------------------------
// scrambler_multiblock
// 64b/66b self-synchronous scrambler/descrambler, polynomial x^58 + x^39 + 1,
// processing NB_BLOCKS coded blocks per clock with the LFSR state chained from
// block to block. Sync headers pass through untouched. One-cycle latency.
// Ports:
//   i_clock, i_reset (async, active low)
//   i_enable            global clock enable; all registers hold when low
//   i_bypass            pass i_data unmodified, state frozen
//   i_descramble        0 = scramble, 1 = descramble
//   i_idle_pattern_mode replace every block by the idle block (scramble only)
//   i_load_seed/i_seed  load a runtime state value
//   i_clear_err         clear the sync-header error counter
//   bus (slave)         i_valid/i_data in, o_data/o_valid out
//   o_sh_err_count      saturating count of invalid sync headers
// Optional feature macro: SCRAMBLER_SH_ERR_COUNT_EN enables the invalid
// sync-header counter (descramble mode); otherwise o_sh_err_count is 0.
// -----------------------------------------------------------------------------
module scrambler_multiblock #(
    parameter int unsigned             NB_BLOCKS       = 4,
    parameter int unsigned             LEN_CODED_BLOCK = 66,
    parameter int unsigned             LEN_SCRAMBLER   = 58,
    parameter int unsigned             NB_SH           = 2,
    parameter logic [LEN_SCRAMBLER-1:0] SEED           = '0,
    parameter int unsigned             NB_ERR_CNT      = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_bypass,
    input  logic                     i_descramble,
    input  logic                     i_idle_pattern_mode,
    input  logic                     i_load_seed,
    input  logic [LEN_SCRAMBLER-1:0] i_seed,
    input  logic                     i_clear_err,
    scrambler_multiblock_if.slave    bus,
    output logic [NB_ERR_CNT-1:0]    o_sh_err_count
);
    localparam int unsigned DATA_W = NB_BLOCKS * LEN_CODED_BLOCK;
    localparam int unsigned PL     = LEN_CODED_BLOCK - NB_SH;
    // x^39 tap sits 39 bits behind the newest state bit.
    localparam int unsigned TAP    = LEN_SCRAMBLER - 39;
    localparam logic [LEN_CODED_BLOCK-1:0] IDLE_BLOCK = 66'h2_1E00_0000_0000_0000;

    logic [LEN_SCRAMBLER-1:0] state_q, state_d;
    logic [DATA_W-1:0]        data_q, scr_data;
    logic                     valid_q;

    logic [LEN_SCRAMBLER-1:0] st;
    logic [LEN_CODED_BLOCK-1:0] blk;
    logic                     outb, fb;

    // Bit-serial LFSR unrolled over every payload bit of every block in the word.
    always_comb begin
        st       = state_q;
        scr_data = '0;
        blk      = '0;
        outb     = 1'b0;
        fb       = 1'b0;
        for (int unsigned b = 0; b < NB_BLOCKS; b++) begin
            blk = bus.i_data[(NB_BLOCKS-1-b)*LEN_CODED_BLOCK +: LEN_CODED_BLOCK];
            if (i_idle_pattern_mode && !i_descramble)
                blk = IDLE_BLOCK;
            for (int unsigned k = 0; k < PL; k++) begin
                outb = blk[PL-1-k] ^ st[TAP] ^ st[0];
                // Scrambler feeds back its output, descrambler its input.
                fb   = i_descramble ? blk[PL-1-k] : outb;
                blk[PL-1-k] = outb;
                st   = {fb, st[LEN_SCRAMBLER-1:1]};
            end
            scr_data[(NB_BLOCKS-1-b)*LEN_CODED_BLOCK +: LEN_CODED_BLOCK] = blk;
        end
        state_d = st;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (i_enable) begin
            valid_q <= bus.i_valid;
            if (bus.i_valid)
                data_q <= i_bypass ? bus.i_data : scr_data;
            // Seed load overrides the advance; the word this cycle still used the old state.
            if (i_load_seed)
                state_q <= i_seed;
            else if (bus.i_valid && !i_bypass)
                state_q <= state_d;
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;

`ifdef SCRAMBLER_SH_ERR_COUNT_EN
    logic [NB_ERR_CNT-1:0] err_cnt_q, err_cnt_d;
    logic [NB_ERR_CNT:0]   err_sum;
    logic [NB_SH-1:0]      sh;
    int unsigned           n_err;

    always_comb begin
        n_err = 0;
        sh    = '0;
        for (int unsigned b = 0; b < NB_BLOCKS; b++) begin
            sh = bus.i_data[(NB_BLOCKS-1-b)*LEN_CODED_BLOCK + PL +: NB_SH];
            if (sh == '0 || sh == '1)
                n_err = n_err + 1;
        end
        err_sum   = {1'b0, err_cnt_q} + (NB_ERR_CNT+1)'(n_err);
        err_cnt_d = err_sum[NB_ERR_CNT] ? '1 : err_sum[NB_ERR_CNT-1:0];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            err_cnt_q <= '0;
        else if (i_enable) begin
            if (i_clear_err)
                err_cnt_q <= '0;
            else if (bus.i_valid && !i_bypass && i_descramble)
                err_cnt_q <= err_cnt_d;
        end
    end

    assign o_sh_err_count = err_cnt_q;
`else
    logic unused_clear_err;
    assign unused_clear_err = i_clear_err;
    assign o_sh_err_count   = '0;
`endif

endmodule

// File: tb/tb_scrambler_multiblock.sv
// -----------------------------------------------------------------------------
// tb_scrambler_multiblock
// Bench for scrambler_multiblock (NB_BLOCKS=4, NB_ERR_CNT=4). A serial-stream
// model (line-bit history, out[n] = d[n] ^ x[n-39] ^ x[n-58]) predicts every
// output word; a compare process checks on every falling edge. Directed tests
// add hand-computed literal expectations and a scramble/descramble round trip.
// -----------------------------------------------------------------------------
module tb_scrambler_multiblock;
    localparam int NB = 4;
    localparam int BL = 66;
    localparam int LS = 58;
    localparam int PL = 64;
    localparam int W  = NB * BL;
    localparam int CW = 4;
    localparam logic [LS-1:0] SEED = 58'h0;
    localparam logic [BL-1:0] IDLE = 66'h2_1E00_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en, bypass, desc, idle, load, clr;
    logic [LS-1:0] seed;
    logic [CW-1:0] cnt;

    scrambler_multiblock_if #(.DATA_W(W)) bus();

    scrambler_multiblock #(
        .NB_BLOCKS(NB), .LEN_CODED_BLOCK(BL), .LEN_SCRAMBLER(LS), .NB_SH(2),
        .SEED(SEED), .NB_ERR_CNT(CW)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_bypass(bypass),
        .i_descramble(desc), .i_idle_pattern_mode(idle), .i_load_seed(load),
        .i_seed(seed), .i_clear_err(clr), .bus(bus), .o_sh_err_count(cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    bit hist[$];               // line bits, last element is the most recent
    logic [W-1:0] exp_data = '0;
    logic         exp_valid = 1'b0;
    int           exp_cnt = 0;
    logic         chk_en = 1'b0;

    function automatic void set_hist(input logic [LS-1:0] s);
        hist.delete();
        for (int k = 0; k < LS; k++) hist.push_back(s[k]);
    endfunction

    function automatic void model_word(input logic [W-1:0] din, input bit dsc, input bit idl,
                                       output logic [W-1:0] dout);
        logic [BL-1:0] blk;
        bit d, o;
        dout = '0;
        for (int b = 0; b < NB; b++) begin
            blk = din[(NB-1-b)*BL +: BL];
            if (idl && !dsc) blk = IDLE;
            for (int k = 0; k < PL; k++) begin
                d = blk[PL-1-k];
                o = d ^ hist[hist.size()-39] ^ hist[hist.size()-58];
                hist.push_back(dsc ? d : o);
                void'(hist.pop_front());
                blk[PL-1-k] = o;
            end
            dout[(NB-1-b)*BL +: BL] = blk;
        end
    endfunction

    function automatic int n_bad_sh(input logic [W-1:0] din);
        logic [1:0] h;
        int n = 0;
        for (int b = 0; b < NB; b++) begin
            h = din[(NB-1-b)*BL + PL +: 2];
            if (h == 2'b00 || h == 2'b11) n++;
        end
        return n;
    endfunction

    initial set_hist(SEED);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_cnt   = 0;
            set_hist(SEED);
        end else if (en) begin
            logic [W-1:0] din;
            din = bus.i_data;
            if (bus.i_valid) begin
                if (bypass) exp_data = din;
                else model_word(din, desc, idle, exp_data);
            end
`ifdef SCRAMBLER_SH_ERR_COUNT_EN
            if (clr) exp_cnt = 0;
            else if (bus.i_valid && !bypass && desc) begin
                exp_cnt = exp_cnt + n_bad_sh(din);
                if (exp_cnt > (1 << CW) - 1) exp_cnt = (1 << CW) - 1;
            end
`endif
            exp_valid = bus.i_valid;
            if (load) set_hist(seed);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("o_valid", W'(bus.o_valid), W'(exp_valid));
            if (exp_valid) check("o_data", bus.o_data, exp_data);
            check("o_sh_err_count", W'(cnt), W'(exp_cnt));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < 9; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic word(input logic [W-1:0] d, input logic v);
        bus.i_data  = d;
        bus.i_valid = v;
        @(negedge clk);
    endtask

    logic [W-1:0] orig [100];
    logic [W-1:0] scr  [100];
    logic [W-1:0] one, hw, r;
    logic [BL-1:0] b0;

    initial begin
        en = 1'b1; bypass = 1'b0; desc = 1'b0; idle = 1'b0; load = 1'b0; clr = 1'b0;
        seed = '0; bus.i_valid = 1'b0; bus.i_data = '0;
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        check("reset_o_valid", W'(bus.o_valid), W'(0));
        check("reset_o_data", bus.o_data, '0);
        check("reset_cnt", W'(cnt), W'(0));
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Zero payload from zero state scrambles to itself.
        one = {NB{66'h1_0000_0000_0000_0000}};
        word(one, 1'b1);
        check("t1_data", bus.o_data, one);
        check("t1_valid", W'(bus.o_valid), W'(1));

        // Idle pattern from zero state; block 0 hand-computed.
        idle = 1'b1;
        word(rnd(), 1'b1);
        b0 = bus.o_data[W-1 -: BL];
        check("idle_blk0", W'(b0), W'(66'h2_1E00_0000_003C_0007));
        for (int i = 0; i < 5; i++) begin
            word(rnd(), 1'b1);
            for (int b = 0; b < NB; b++) begin
                b0 = bus.o_data[(NB-1-b)*BL +: BL];
                check("idle_sh", W'(b0[BL-1 -: 2]), W'(2'b10));
            end
        end
        idle = 1'b0;

        // Seed load alongside a valid word.
        seed = 58'h155_5555_5555_5555;
        load = 1'b1;
        word(rnd(), 1'b1);
        load = 1'b0;
        for (int i = 0; i < 4; i++) word(rnd(), 1'b1);

        // Bypass window; state frozen across it.
        bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r = rnd();
            word(r, 1'b1);
            check("bypass_data", bus.o_data, r);
        end
        bypass = 1'b0;
        for (int i = 0; i < 5; i++) word(rnd(), 1'b1);

        // Enable low holds everything; valid gaps.
        en = 1'b0;
        for (int i = 0; i < 3; i++) word(rnd(), 1'b1);
        en = 1'b1;
        word(rnd(), 1'b0);
        word(rnd(), 1'b0);
        word(rnd(), 1'b1);

        // Round trip: scramble from all-ones, descramble from zero.
        seed = 58'h3FF_FFFF_FFFF_FFFF;
        load = 1'b1;
        word('0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            orig[i] = rnd();
            word(orig[i], 1'b1);
            scr[i] = bus.o_data;
        end
        desc = 1'b1;
        seed = '0;
        load = 1'b1;
        word('0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 100; i++) begin
            word(scr[i], 1'b1);
            if (i >= 1) check("roundtrip", bus.o_data, orig[i]);
        end

        // Sync-header error counter: headers {00,11,01,10}.
        clr = 1'b1;
        word('0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            hw = rnd();
            hw[3*BL+PL +: 2] = 2'b00;
            hw[2*BL+PL +: 2] = 2'b11;
            hw[1*BL+PL +: 2] = 2'b01;
            hw[0*BL+PL +: 2] = 2'b10;
            word(hw, 1'b1);
`ifdef SCRAMBLER_SH_ERR_COUNT_EN
            if (i < 3) check("cnt_step", W'(cnt), W'(2 * (i + 1)));
            if (i == 10) check("cnt_sat", W'(cnt), W'(4'hF));
`else
            if (i < 3 || i == 10) check("cnt_off", W'(cnt), W'(0));
`endif
        end
        clr = 1'b1;
        word(hw, 1'b1);
        clr = 1'b0;
        check("cnt_clear", W'(cnt), W'(0));

        // Scramble mode must not count.
        desc = 1'b0;
        word(hw, 1'b1);
        check("cnt_scramble", W'(cnt), W'(0));

        // Reset pulse mid-stream.
        word(rnd(), 1'b1);
        bus.i_data = rnd();
        #3 rst_n = 1'b0;
        #1;
        check("midreset_valid", W'(bus.o_valid), W'(0));
        check("midreset_data", bus.o_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) word(rnd(), 1'b1);
        word('0, 1'b0);
        word('0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
